// File: rtl/dmi_pkg.sv
// Shared types for the DMI arbiter: op/response codes, FSM states
// and default bus widths.
package dmi_pkg;

    localparam int unsigned DMI_ADDR_W = 7;
    localparam int unsigned DMI_DATA_W = 32;

    typedef enum logic [1:0] {
        DMI_NOP   = 2'd0,
        DMI_READ  = 2'd1,
        DMI_WRITE = 2'd2
    } dmi_op_e;

    typedef enum logic [1:0] {
        DMI_SUCCESS = 2'd0,
        DMI_FAILED  = 2'd2
    } dmi_resp_e;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_REQ,
        ST_WAIT,
        ST_RSP,
        ST_FLUSH
    } arb_state_e;

endpackage

// File: rtl/dmi_arbiter_rr_arb2.sv
// Two-input round-robin pick; the pointer remembers the last winner
// and moves only when a grant is actually taken.
module rr_arb2 (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] req_i,
    input  logic       upd_i,
    output logic [1:0] gnt_o,
    output logic       idx_o
);

    logic last_q;

    always_comb begin
        idx_o = (req_i == 2'b11) ? ~last_q : req_i[1];
        gnt_o = 2'b00;
        if (|req_i) begin
            gnt_o = idx_o ? 2'b10 : 2'b01;
        end
    end

    // Pointer starts at requester 1 so requester 0 wins the first contest.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_q <= 1'b1;
        end else if (upd_i && (|req_i)) begin
            last_q <= idx_o;
        end
    end

endmodule

// File: rtl/dmi_arbiter.sv
// Shares the Debug Module DMI port between two transports, one
// transaction in flight, with a response timeout and stale-response flush.
module dmi_arbiter
    import dmi_pkg::*;
#(
    parameter int unsigned ADDR_W  = DMI_ADDR_W,
    parameter int unsigned DATA_W  = DMI_DATA_W,
    parameter int unsigned TIMEOUT = 1023
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [1:0]            s_req_valid_i,
    output logic [1:0]            s_req_ready_o,
    input  logic [2*ADDR_W-1:0]   s_req_addr_i,
    input  logic [2*DATA_W-1:0]   s_req_data_i,
    input  logic [3:0]            s_req_op_i,
    output logic [1:0]            s_rsp_valid_o,
    input  logic [1:0]            s_rsp_ready_i,
    output logic [DATA_W-1:0]     s_rsp_data_o,
    output logic [1:0]            s_rsp_op_o,
    output logic                  m_req_valid_o,
    input  logic                  m_req_ready_i,
    output logic [ADDR_W-1:0]     m_req_addr_o,
    output logic [DATA_W-1:0]     m_req_data_o,
    output logic [1:0]            m_req_op_o,
    input  logic                  m_rsp_valid_i,
    output logic                  m_rsp_ready_o,
    input  logic [DATA_W-1:0]     m_rsp_data_i,
    input  logic [1:0]            m_rsp_op_i,
    output logic [1:0]            grant_o,
    output logic                  timeout_o
);

    localparam int unsigned TW = $clog2(TIMEOUT + 1);
    localparam logic [TW-1:0] TLAST = TW'(TIMEOUT - 1);
    localparam logic [TW-1:0] TMAX  = TW'(TIMEOUT);

    arb_state_e        state_q;
    logic              owner_q;
    logic              flush_q;
    logic [TW-1:0]     timer_q;
    logic [TW-1:0]     timer_d;
    logic [1:0]        sreq_rdy_q;
    logic              timeout_q;
    logic [ADDR_W-1:0] mreq_addr_q;
    logic [DATA_W-1:0] mreq_data_q;
    logic [1:0]        mreq_op_q;
    logic [DATA_W-1:0] rsp_data_q;
    logic [1:0]        rsp_op_q;

    logic [1:0]        arb_gnt;
    logic              arb_idx;
    logic              expire;
    logic [1:0]        owner_oh;

    rr_arb2 u_rr (
        .clk   (clk),
        .rst_n (rst_n),
        .req_i (s_req_valid_i),
        .upd_i (state_q == ST_IDLE),
        .gnt_o (arb_gnt),
        .idx_o (arb_idx)
    );

    // >= rather than == so a request accepted on the last REQ cycle
    // still times out in WAIT once the counter has saturated.
    always_comb begin
        timer_d  = (timer_q == TMAX) ? timer_q : timer_q + TW'(1);
        expire   = (timer_q >= TLAST);
        owner_oh = owner_q ? 2'b10 : 2'b01;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            owner_q     <= 1'b0;
            flush_q     <= 1'b0;
            timer_q     <= '0;
            sreq_rdy_q  <= '0;
            timeout_q   <= 1'b0;
            mreq_addr_q <= '0;
            mreq_data_q <= '0;
            mreq_op_q   <= '0;
            rsp_data_q  <= '0;
            rsp_op_q    <= '0;
        end else begin
            sreq_rdy_q <= '0;
            timeout_q  <= 1'b0;
            timer_q    <= timer_d;
            unique case (state_q)
                ST_IDLE: begin
                    timer_q <= '0;
                    if (|s_req_valid_i) begin
                        sreq_rdy_q  <= arb_gnt;
                        owner_q     <= arb_idx;
                        mreq_addr_q <= arb_idx ? s_req_addr_i[2*ADDR_W-1:ADDR_W]
                                               : s_req_addr_i[ADDR_W-1:0];
                        mreq_data_q <= arb_idx ? s_req_data_i[2*DATA_W-1:DATA_W]
                                               : s_req_data_i[DATA_W-1:0];
                        mreq_op_q   <= arb_idx ? s_req_op_i[3:2] : s_req_op_i[1:0];
                        state_q     <= ST_REQ;
                    end
                end
                ST_REQ: begin
                    if (m_req_ready_i) begin
                        state_q <= ST_WAIT;
                    end else if (expire) begin
                        rsp_data_q <= '0;
                        rsp_op_q   <= DMI_FAILED;
                        timeout_q  <= 1'b1;
                        state_q    <= ST_RSP;
                    end
                end
                ST_WAIT: begin
                    if (m_rsp_valid_i) begin
                        rsp_data_q <= m_rsp_data_i;
                        rsp_op_q   <= m_rsp_op_i;
                        state_q    <= ST_RSP;
                    end else if (expire) begin
                        rsp_data_q <= '0;
                        rsp_op_q   <= DMI_FAILED;
                        timeout_q  <= 1'b1;
                        flush_q    <= 1'b1;
                        state_q    <= ST_RSP;
                    end
                end
                ST_RSP: begin
                    timer_q <= '0;
                    if (s_rsp_ready_i[owner_q]) begin
                        state_q <= flush_q ? ST_FLUSH : ST_IDLE;
                    end
                end
                ST_FLUSH: begin
                    if (m_rsp_valid_i || expire) begin
                        flush_q <= 1'b0;
                        state_q <= ST_IDLE;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    always_comb begin
        s_req_ready_o = sreq_rdy_q;
        s_rsp_valid_o = (state_q == ST_RSP) ? owner_oh : 2'b00;
        s_rsp_data_o  = rsp_data_q;
        s_rsp_op_o    = rsp_op_q;
        m_req_valid_o = (state_q == ST_REQ);
        m_req_addr_o  = mreq_addr_q;
        m_req_data_o  = mreq_data_q;
        m_req_op_o    = mreq_op_q;
        m_rsp_ready_o = (state_q == ST_WAIT) || (state_q == ST_FLUSH);
        grant_o       = ((state_q == ST_REQ) || (state_q == ST_WAIT) ||
                         (state_q == ST_RSP)) ? owner_oh : 2'b00;
        timeout_o     = timeout_q;
    end

endmodule

// File: tb/tb_dmi_arbiter.sv
// Directed plus randomized transactions against a transaction-level
// model of arbitration, latency, timeout and flush behaviour.
module tb_dmi_arbiter;
    import dmi_pkg::*;

    localparam int AW = 7;
    localparam int DW = 32;
    localparam int TO = 16;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic [1:0]      s_req_valid_i;
    logic [1:0]      s_req_ready_o;
    logic [2*AW-1:0] s_req_addr_i;
    logic [2*DW-1:0] s_req_data_i;
    logic [3:0]      s_req_op_i;
    logic [1:0]      s_rsp_valid_o;
    logic [1:0]      s_rsp_ready_i;
    logic [DW-1:0]   s_rsp_data_o;
    logic [1:0]      s_rsp_op_o;
    logic            m_req_valid_o;
    logic            m_req_ready_i;
    logic [AW-1:0]   m_req_addr_o;
    logic [DW-1:0]   m_req_data_o;
    logic [1:0]      m_req_op_o;
    logic            m_rsp_valid_i;
    logic            m_rsp_ready_o;
    logic [DW-1:0]   m_rsp_data_i;
    logic [1:0]      m_rsp_op_i;
    logic [1:0]      grant_o;
    logic            timeout_o;

    logic [AW-1:0] ra [2];
    logic [DW-1:0] rd [2];
    logic [1:0]    ro [2];

    assign s_req_addr_i = {ra[1], ra[0]};
    assign s_req_data_i = {rd[1], rd[0]};
    assign s_req_op_i   = {ro[1], ro[0]};

    int tests = 0;
    int fails = 0;
    int last  = 1;

    dmi_arbiter #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT(TO)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .s_req_valid_i (s_req_valid_i),
        .s_req_ready_o (s_req_ready_o),
        .s_req_addr_i  (s_req_addr_i),
        .s_req_data_i  (s_req_data_i),
        .s_req_op_i    (s_req_op_i),
        .s_rsp_valid_o (s_rsp_valid_o),
        .s_rsp_ready_i (s_rsp_ready_i),
        .s_rsp_data_o  (s_rsp_data_o),
        .s_rsp_op_o    (s_rsp_op_o),
        .m_req_valid_o (m_req_valid_o),
        .m_req_ready_i (m_req_ready_i),
        .m_req_addr_o  (m_req_addr_o),
        .m_req_data_o  (m_req_data_o),
        .m_req_op_o    (m_req_op_o),
        .m_rsp_valid_i (m_rsp_valid_i),
        .m_rsp_ready_o (m_rsp_ready_o),
        .m_rsp_data_i  (m_rsp_data_i),
        .m_rsp_op_i    (m_rsp_op_i),
        .grant_o       (grant_o),
        .timeout_o     (timeout_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [127:0] obs,
                       input logic [127:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic new_payload(input int r);
        ra[r] = AW'($urandom);
        rd[r] = $urandom;
        ro[r] = 2'($urandom_range(0, 2));
    endtask

    function automatic logic [83:0] all_out();
        return {s_req_ready_o, s_rsp_valid_o, s_rsp_data_o, s_rsp_op_o,
                m_req_valid_o, m_req_addr_o, m_req_data_o, m_req_op_o,
                m_rsp_ready_o, grant_o, timeout_o};
    endfunction

    // Called at a negedge with the DUT idle and requests already driven.
    // rq/rs: DM ready/response delay in cycles (-1 = never);
    // take: cycles the owner stalls the response; late: flush-time
    // stale response delay (-1 = never); refill: owner re-requests.
    task automatic txn(input int rq, input int rs, input int take,
                       input int late, input bit refill,
                       input logic [DW-1:0] dmd, input logic [1:0] dmo,
                       output int own);
        int p, c, w, f, idx, exp_lat, flen;
        bit exp_fail, exp_flush, got, seen_to;
        logic [AW-1:0] ea;
        logic [DW-1:0] ed, exd;
        logic [1:0] eo, oh, exo;
        own  = (s_req_valid_i == 2'b11) ? 1 - last : (s_req_valid_i[1] ? 1 : 0);
        last = own;
        oh   = (own == 1) ? 2'b10 : 2'b01;
        ea = ra[own];
        ed = rd[own];
        eo = ro[own];
        if (rq < 0) begin
            exp_fail = 1; exp_flush = 0; idx = TO - 1;
        end else if (rs >= 0 && rq + 1 + rs <= TO - 1) begin
            exp_fail = 0; exp_flush = 0; idx = rq + 1 + rs;
        end else begin
            exp_fail = 1; exp_flush = 1; idx = TO - 1;
        end
        exp_lat = idx + 2;
        exd = exp_fail ? '0 : dmd;
        exo = exp_fail ? 2'(DMI_FAILED) : dmo;
        p = 0; c = 0; w = 0; got = 0; seen_to = 0;
        while (!got && p < TO + 8) begin
            @(negedge clk);
            p++;
            if (s_rsp_valid_o != 2'b00) begin
                got = 1;
            end else begin
                if (p == 1) begin
                    chk("req_ready", s_req_ready_o, oh);
                    chk("m_req_fields", {m_req_addr_o, m_req_data_o, m_req_op_o},
                        {ea, ed, eo});
                    if (refill) new_payload(own);
                    else s_req_valid_i[own] = 1'b0;
                end
                if (p == 2) chk("req_ready_pulse", s_req_ready_o, 2'b00);
                chk("grant_busy", grant_o, oh);
                if (timeout_o) seen_to = 1;
                m_req_ready_i = 1'b0;
                m_rsp_valid_i = 1'b0;
                if (m_req_valid_o) begin
                    m_req_ready_i = (c == rq);
                    c++;
                end else if (m_rsp_ready_o) begin
                    if (w == rs) begin
                        m_rsp_valid_i = 1'b1;
                        m_rsp_data_i  = dmd;
                        m_rsp_op_i    = dmo;
                    end
                    w++;
                end
            end
        end
        m_req_ready_i = 1'b0;
        m_rsp_valid_i = 1'b0;
        chk("rsp_seen", got, 1'b1);
        chk("rsp_latency", p, exp_lat);
        chk("rsp_owner", s_rsp_valid_o, oh);
        chk("rsp_data", s_rsp_data_o, exd);
        chk("rsp_op", s_rsp_op_o, exo);
        chk("timeout_pulse", {seen_to, timeout_o}, {1'b0, exp_fail});
        chk("m_req_dropped", m_req_valid_o, 1'b0);
        s_rsp_ready_i = ~oh;
        for (int k = 0; k < take; k++) begin
            @(negedge clk);
            chk("rsp_hold", {s_rsp_valid_o, s_rsp_data_o, s_rsp_op_o, grant_o,
                             timeout_o, s_req_ready_o},
                {oh, exd, exo, oh, 1'b0, 2'b00});
        end
        s_rsp_ready_i = oh;
        @(negedge clk);
        s_rsp_ready_i = 2'b00;
        chk("rsp_release", {s_rsp_valid_o, grant_o, timeout_o, m_rsp_ready_o},
            {2'b00, 2'b00, 1'b0, exp_flush});
        if (exp_flush) begin
            flen = (late >= 0 && late <= TO - 1) ? late + 1 : TO;
            f = 0;
            while (m_rsp_ready_o && f < TO + 4) begin
                chk("flush_no_grant", {grant_o, s_req_ready_o}, 4'b0000);
                m_rsp_valid_i = (f == late);
                m_rsp_data_i  = $urandom;
                m_rsp_op_i    = 2'b00;
                f++;
                @(negedge clk);
            end
            m_rsp_valid_i = 1'b0;
            chk("flush_len", f, flen);
            chk("flush_exit", {grant_o, s_rsp_valid_o}, 4'b0000);
        end
    endtask

    initial begin
        int own, prev, rq, rs, late;
        logic [1:0] nv;
        s_req_valid_i = 2'b00;
        s_rsp_ready_i = 2'b00;
        m_req_ready_i = 1'b0;
        m_rsp_valid_i = 1'b0;
        m_rsp_data_i  = '0;
        m_rsp_op_i    = 2'b00;
        for (int r = 0; r < 2; r++) begin
            ra[r] = '0; rd[r] = '0; ro[r] = '0;
        end
        repeat (3) @(negedge clk);
        chk("reset_outputs", all_out(), 84'd0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("idle_outputs", all_out(), 84'd0);

        s_req_valid_i = 2'b01;
        ra[0] = 7'h11; rd[0] = 32'h0; ro[0] = 2'd1;
        txn(0, 0, 0, -1, 0, 32'h0000_0382, 2'd0, own);
        chk("first_owner", own, 0);

        s_req_valid_i = 2'b11;
        new_payload(0);
        new_payload(1);
        prev = -1;
        for (int i = 0; i < 4; i++) begin
            txn($urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 2),
                -1, 1, $urandom, 2'd0, own);
            if (prev >= 0) chk("alternate", own, 1 - prev);
            prev = own;
        end

        txn(0, -1, 1, 3, 0, $urandom, 2'd0, own);
        prev = own;
        txn(0, 0, 0, -1, 0, $urandom, 2'd0, own);
        chk("after_flush_other", own, 1 - prev);

        s_req_valid_i = 2'b01;
        new_payload(0);
        txn(-1, 0, 2, -1, 0, $urandom, 2'd0, own);

        s_req_valid_i = 2'b10;
        new_payload(1);
        txn(0, TO - 2, 5, -1, 0, $urandom, 2'd2, own);
        s_req_valid_i = 2'b10;
        new_payload(1);
        txn(0, TO - 1, 0, 2, 0, $urandom, 2'd0, own);

        for (int i = 0; i < 24; i++) begin
            nv = 2'($urandom_range(0, 3));
            for (int r = 0; r < 2; r++) begin
                if (nv[r] && !s_req_valid_i[r]) begin
                    new_payload(r);
                    s_req_valid_i[r] = 1'b1;
                end
            end
            if (s_req_valid_i == 2'b00) begin
                new_payload(0);
                s_req_valid_i = 2'b01;
            end
            rq   = ($urandom_range(0, 7) == 0) ? -1 : $urandom_range(0, 3);
            rs   = ($urandom_range(0, 5) == 0) ? -1 : $urandom_range(0, 4);
            late = ($urandom_range(0, 3) == 0) ? -1 : $urandom_range(0, 4);
            txn(rq, rs, $urandom_range(0, 3), late, 1'($urandom_range(0, 1)),
                $urandom, ($urandom_range(0, 1) == 1) ? 2'd2 : 2'd0, own);
        end

        s_req_valid_i = 2'b10;
        new_payload(1);
        @(negedge clk);
        chk("pre_reset_grant", grant_o, 2'b10);
        m_req_ready_i = 1'b1;
        @(negedge clk);
        m_req_ready_i = 1'b0;
        chk("pre_reset_wait", m_rsp_ready_o, 1'b1);
        #2 rst_n = 1'b0;
        #1;
        chk("async_reset", all_out(), 84'd0);
        s_req_valid_i = 2'b11;
        new_payload(0);
        @(negedge clk);
        chk("held_reset", all_out(), 84'd0);
        rst_n = 1'b1;
        last  = 1;
        txn(0, 0, 0, -1, 0, $urandom, 2'd0, own);
        chk("post_reset_owner", own, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
